// File: rtl/if_pkg.sv
// Shared types and defaults for the instruction-fetch stage: FSM state
// encoding, reset PC, bubble instruction and the PC step.
package if_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DRAIN = 3'd4
  } fetch_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // Redirect targets are always word addresses.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register read by decode. Priority: load > bubble > hold;
// a cycle with no control asserted falls back to a bubble.
module if_id_reg
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_bubble,
  input  logic        i_hold,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  output logic        o_valid
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;
  logic        r_valid;

  // IF/ID contents update
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_inst  <= NOP_INST;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_inst  <= i_inst;
      r_pc    <= i_pc;
      r_valid <= 1'b1;
    end else if (i_bubble) begin
      r_inst  <= NOP_INST;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
    end else if (i_hold) begin
      r_inst  <= r_inst;
      r_pc    <= r_pc;
      r_valid <= r_valid;
    end else begin
      r_inst  <= NOP_INST;
      r_pc    <= 32'd0;
      r_valid <= 1'b0;
    end
  end

  assign o_inst  = r_inst;
  assign o_pc    = r_pc;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem FSM and IF/ID register.
// Define IF_PERF_EN to add the fetch_cnt / stall_cnt performance counters.
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clk_50,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst_out,
  output logic [31:0] pc_out,
  output logic        inst_valid
`ifdef IF_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_nxt;
  logic [31:0]  r_hold_inst;
  logic [31:0]  r_hold_pc;
  logic         r_hold_vld;
  logic [31:0]  w_hold_inst_nxt;
  logic [31:0]  w_hold_pc_nxt;
  logic         w_hold_vld_nxt;
  logic         w_req;
  logic [31:0]  w_addr;
  logic         w_load;
  logic         w_bubble;
  logic         w_hold;
  logic [31:0]  w_ld_inst;
  logic [31:0]  w_ld_pc;
  logic [31:0]  w_pc_inc;
  logic [31:0]  w_target;

  assign w_pc_inc = r_pc + PC_STEP;
  assign w_target = align_word(branch_target);

  // Next-state, PC, hold-buffer and IF/ID control decode (flush > stall > normal)
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_hold_inst_nxt = r_hold_inst;
    w_hold_pc_nxt   = r_hold_pc;
    w_hold_vld_nxt  = r_hold_vld;
    w_req           = 1'b0;
    w_addr          = r_pc;
    w_load          = 1'b0;
    w_bubble        = ~stall;
    w_hold          = stall;
    w_ld_inst       = imem_rdata;
    w_ld_pc         = r_pc;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (flush) begin
          w_pc_nxt = w_target;
          w_bubble = 1'b1;
          w_hold   = 1'b0;
        end else begin
          w_pc_nxt = r_pc;
        end
      end
      S_REQ: begin
        w_req  = 1'b1;
        w_addr = r_pc;
        if (flush) begin
          w_pc_nxt    = w_target;
          w_bubble    = 1'b1;
          w_hold      = 1'b0;
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) begin
          w_pc_nxt = w_target;
          w_bubble = 1'b1;
          w_hold   = 1'b0;
          if (imem_valid) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else if (imem_valid) begin
          if (stall) begin
            w_hold_inst_nxt = imem_rdata;
            w_hold_pc_nxt   = r_pc;
            w_hold_vld_nxt  = 1'b1;
            w_state_nxt     = S_HOLD;
          end else begin
            // Back-to-back issue keeps a 1-cycle memory at one fetch per cycle.
            w_load   = 1'b1;
            w_pc_nxt = w_pc_inc;
            w_req    = 1'b1;
            w_addr   = w_pc_inc;
          end
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_HOLD: begin
        if (flush) begin
          w_hold_inst_nxt = 32'd0;
          w_hold_pc_nxt   = 32'd0;
          w_hold_vld_nxt  = 1'b0;
          w_pc_nxt        = w_target;
          w_bubble        = 1'b1;
          w_hold          = 1'b0;
          w_state_nxt     = S_REQ;
        end else if (!stall) begin
          w_load         = 1'b1;
          w_ld_inst      = r_hold_inst;
          w_ld_pc        = r_hold_pc;
          w_hold_vld_nxt = 1'b0;
          w_pc_nxt       = w_pc_inc;
          w_state_nxt    = S_REQ;
        end else begin
          w_state_nxt = S_HOLD;
        end
      end
      S_DRAIN: begin
        if (flush) begin
          w_pc_nxt = w_target;
          w_bubble = 1'b1;
          w_hold   = 1'b0;
          // A response landing with the flush still retires the outstanding request.
          if (imem_valid) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end else if (imem_valid) begin
          w_state_nxt = S_REQ;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_bubble    = 1'b1;
        w_hold      = 1'b0;
      end
    endcase
  end

  // FSM state, PC and hold buffer
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_hold_inst <= 32'd0;
      r_hold_pc   <= 32'd0;
      r_hold_vld  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_hold_inst <= w_hold_inst_nxt;
      r_hold_pc   <= w_hold_pc_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
    end
  end

  assign imem_req  = w_req;
  assign imem_addr = w_addr;

  if_id_reg #(
    .NOP_INST (NOP_INST)
  ) u_if_id_reg (
    .clk_50   (clk_50),
    .rst      (rst),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_hold   (w_hold),
    .i_inst   (w_ld_inst),
    .i_pc     (w_ld_pc),
    .o_inst   (inst_out),
    .o_pc     (pc_out),
    .o_valid  (inst_valid)
  );

`ifdef IF_PERF_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  // Performance counters, free-running and wrapping
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= 32'd0;
      r_stall_cnt <= 32'd0;
    end else begin
      if (w_load) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end else begin
        r_fetch_cnt <= r_fetch_cnt;
      end
      if (stall && (r_state != S_IDLE)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end else begin
        r_stall_cnt <= r_stall_cnt;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural variable-latency imem.
module tb_if_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk_50 = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_valid;
`ifdef IF_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int          vec_cnt = 0;
  int          err_cnt = 0;
  int          mem_lat = 1;
  int          mem_cnt = 0;
  bit          mem_en  = 1'b1;
  logic [31:0] mem_addr_q = 32'd0;

  if_fetch_stage dut (
    .clk_50        (clk_50),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_rdata    (imem_rdata),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .inst_valid    (inst_valid)
`ifdef IF_PERF_EN
    ,
    .fetch_cnt     (fetch_cnt),
    .stall_cnt     (stall_cnt)
`endif
  );

  always #5 clk_50 = ~clk_50;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h00A0_0093;
      32'h0000_0004: return 32'h0010_0113;
      32'h0000_0008: return 32'h1234_5678;
      default:       return a ^ 32'hDEAD_0000;
    endcase
  endfunction

  task automatic check_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  // One clock: sample the request before the edge, then advance the memory model.
  task automatic tick();
    logic        req_s;
    logic [31:0] addr_s;
    @(negedge clk_50);
    req_s  = imem_req;
    addr_s = imem_addr;
    @(posedge clk_50);
    #1;
    if (mem_en) begin
      if (req_s) begin
        mem_cnt    = mem_lat;
        mem_addr_q = addr_s;
      end else if (mem_cnt > 0) begin
        mem_cnt--;
      end
      imem_valid = (mem_cnt == 1);
      imem_rdata = imem_valid ? mem_word(mem_addr_q) : 32'd0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_target = 32'd0;
    imem_valid = 1'b0; imem_rdata = 32'd0;
    repeat (2) @(posedge clk_50);
    #1;
    check_vec("rst_inst", inst_out, NOP);
    check_vec("rst_pc", pc_out, 32'd0);
    check_vec("rst_valid", inst_valid, 32'd0);
    check_vec("rst_req", imem_req, 32'd0);
    rst = 1'b0;

    // Startup with 1-cycle memory
    tick();
    check_vec("s1_req", imem_req, 32'd1);
    check_vec("s1_addr", imem_addr, 32'd0);
    check_vec("s1_valid", inst_valid, 32'd0);
    tick();
    check_vec("s2_valid", inst_valid, 32'd0);
    check_vec("s2_req", imem_req, 32'd1);
    check_vec("s2_addr", imem_addr, 32'd4);
    tick();
    check_vec("s3_valid", inst_valid, 32'd1);
    check_vec("s3_inst", inst_out, 32'h00A0_0093);
    check_vec("s3_pc", pc_out, 32'd0);
    check_vec("s3_req", imem_req, 32'd1);
    tick();
    check_vec("s4_inst", inst_out, 32'h0010_0113);
    check_vec("s4_pc", pc_out, 32'd4);

    // Stall while the pc 8 response arrives
    stall = 1'b1;
    #1;
    check_vec("st_noissue", imem_req, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_vec("st_hold_inst", inst_out, 32'h0010_0113);
      check_vec("st_hold_pc", pc_out, 32'd4);
      check_vec("st_req", imem_req, 32'd0);
    end
    stall = 1'b0;
    tick();
    check_vec("st_rel_inst", inst_out, 32'h1234_5678);
    check_vec("st_rel_pc", pc_out, 32'd8);
    check_vec("st_rel_valid", inst_valid, 32'd1);
    check_vec("st_rel_req", imem_req, 32'd1);
    check_vec("st_rel_addr", imem_addr, 32'd12);
`ifdef IF_PERF_EN
    check_vec("perf_fetch", fetch_cnt, 32'd3);
    check_vec("perf_stall", stall_cnt, 32'd3);
`endif

    // 3-cycle memory, flush one cycle after REQ (unaligned target)
    mem_lat = 3;
    tick();
    flush = 1'b1; branch_target = 32'h0000_0103;
    #1;
    check_vec("fl_req", imem_req, 32'd0);
    tick();
    flush = 1'b0;
    check_vec("fl_valid", inst_valid, 32'd0);
    check_vec("fl_inst", inst_out, NOP);
    check_vec("fl_pc", pc_out, 32'd0);
    tick();
    check_vec("dr_req", imem_req, 32'd0);
    tick();
    check_vec("dr_done_req", imem_req, 32'd1);
    check_vec("dr_done_addr", imem_addr, 32'h0000_0100);
    check_vec("dr_done_valid", inst_valid, 32'd0);

    // Flush coincident with a response in WAIT
    repeat (3) tick();
    check_vec("fv_rsp", imem_valid, 32'd1);
    flush = 1'b1; branch_target = 32'h0000_0040;
    #1;
    check_vec("fv_noissue", imem_req, 32'd0);
    tick();
    flush = 1'b0;
    check_vec("fv_req", imem_req, 32'd1);
    check_vec("fv_addr", imem_addr, 32'h0000_0040);
    check_vec("fv_valid", inst_valid, 32'd0);
    mem_lat = 1;
    tick();
    tick();
    check_vec("fv_inst", inst_out, 32'hDEAD_0040);
    check_vec("fv_pc", pc_out, 32'h0000_0040);

    // Flush while stalled in HOLD
    stall = 1'b1;
    tick();
    check_vec("hf_hold_pc", pc_out, 32'h0000_0040);
    flush = 1'b1; branch_target = 32'h0000_0200;
    tick();
    flush = 1'b0;
    check_vec("hf_valid", inst_valid, 32'd0);
    check_vec("hf_inst", inst_out, NOP);
    check_vec("hf_req", imem_req, 32'd1);
    check_vec("hf_addr", imem_addr, 32'h0000_0200);
    tick();
    stall = 1'b0;
    #1;
    check_vec("hf_issue_addr", imem_addr, 32'h0000_0204);
    tick();
    check_vec("hf_inst2", inst_out, 32'hDEAD_0200);
    check_vec("hf_pc2", pc_out, 32'h0000_0200);

    // Reset mid-WAIT, late response ignored in IDLE
    rst = 1'b1;
    #1;
    check_vec("mr_inst", inst_out, NOP);
    check_vec("mr_pc", pc_out, 32'd0);
    check_vec("mr_valid", inst_valid, 32'd0);
    check_vec("mr_req", imem_req, 32'd0);
    mem_en = 1'b0; imem_valid = 1'b0; mem_cnt = 0;
    @(posedge clk_50);
    #1;
    rst = 1'b0;
`ifdef IF_PERF_EN
    check_vec("mr_fetch", fetch_cnt, 32'd0);
    check_vec("mr_stall", stall_cnt, 32'd0);
`endif
    imem_valid = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    tick();
    imem_valid = 1'b0; imem_rdata = 32'd0;
    check_vec("late_valid", inst_valid, 32'd0);
    check_vec("late_req", imem_req, 32'd1);
    check_vec("late_addr", imem_addr, 32'd0);
    mem_en = 1'b1;
    tick();
    tick();
    check_vec("re_inst", inst_out, 32'h00A0_0093);
    check_vec("re_valid", inst_valid, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
